// File: rtl/seq_divider8.sv
// seq_divider8: iterative 8-bit unsigned restoring divider, one quotient bit per cycle.
// start/busy/done handshake with a fixed 9-cycle latency from accept to done.
module seq_divider8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [7:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [7:0] quotient,
  output logic [7:0] remainder,
  output logic       div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [8:0] rem_q, rem_d;
  logic [7:0] shq_q, shq_d;
  logic [7:0] dvs_q, dvs_d;
  logic [2:0] cnt_q, cnt_d;
  logic       zero_q, zero_d;
  logic [7:0] quot_q, quot_d;
  logic [7:0] remout_q, remout_d;
  logic       dbz_q, dbz_d;
  logic       accept;
  logic [8:0] trial;
  logic [8:0] diff;
  logic       ge;

  // The top remainder bit is architecturally zero at completion and never feeds the trial.
  logic       rem_msb_unused;
  assign rem_msb_unused = rem_q[8];

  assign accept = start && (state_q == IDLE || state_q == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rem_q    <= 9'd0;
      shq_q    <= 8'd0;
      dvs_q    <= 8'd0;
      cnt_q    <= 3'd0;
      zero_q   <= 1'b0;
      quot_q   <= 8'd0;
      remout_q <= 8'd0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      shq_q    <= shq_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      zero_q   <= zero_d;
      quot_q   <= quot_d;
      remout_q <= remout_d;
      dbz_q    <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == 3'd7) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Trial subtract in two's complement; a zero divisor always succeeds, giving all-ones quotient.
  always_comb begin
    trial    = {rem_q[7:0], shq_q[7]};
    diff     = trial + ~{1'b0, dvs_q} + 9'd1;
    ge       = (trial >= {1'b0, dvs_q});
    rem_d    = rem_q;
    shq_d    = shq_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    zero_d   = zero_q;
    quot_d   = quot_q;
    remout_d = remout_q;
    dbz_d    = dbz_q;
    if (accept) begin
      rem_d  = 9'd0;
      shq_d  = dividend;
      dvs_d  = divisor;
      cnt_d  = 3'd0;
      zero_d = (divisor == 8'd0);
    end else if (state_q == RUN) begin
      rem_d = ge ? diff : trial;
      shq_d = {shq_q[6:0], ge};
      cnt_d = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        quot_d   = shq_d;
        remout_d = rem_d[7:0];
        dbz_d    = zero_q;
      end
    end
  end

  always_comb begin
    busy        = (state_q == RUN);
    done        = (state_q == DONE);
    quotient    = quot_q;
    remainder   = remout_q;
    div_by_zero = dbz_q;
  end

endmodule

// File: tb/tb_seq_divider8.sv
// Self-checking bench for seq_divider8: directed scenarios plus a randomized back-to-back sweep
// compared against a plain-arithmetic division model.
module tb_seq_divider8;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int errors;
  int checks;

  seq_divider8 dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ref_q(input int a, input int b);
    if (b == 0) return 255;
    return a / b;
  endfunction

  function automatic int ref_r(input int a, input int b);
    if (b == 0) return a;
    return a % b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand pair with start for a single edge; afterwards the bench sits in cycle 1.
  task automatic launch(input int a, input int b);
    start    = 1'b1;
    dividend = 8'(a);
    divisor  = 8'(b);
    tick();
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 8'($urandom);
  endtask

  // Returns the cycle number (accept edge = 0) at which done is seen, bounded at 30.
  task automatic wait_done(input int first, output int cyc);
    cyc = first;
    while (done !== 1'b1 && cyc < 30) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    dividend = 8'd0;
    divisor = 8'd0;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: busy=%b done=%b expected 0 0", busy, done);
    end
    checks++;
    if (quotient !== 8'd0 || remainder !== 8'd0 || div_by_zero !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_results: q=%0d r=%0d dz=%b expected 0 0 0", quotient, remainder, div_by_zero);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_idle: busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    int bad_busy;
    launch(200, 7);
    bad_busy = 0;
    for (int c = 1; c <= 8; c++) begin
      if (busy !== 1'b1 || done !== 1'b0) bad_busy++;
      if (c < 8) tick();
    end
    checks++;
    if (bad_busy != 0) begin
      errors++;
      $display("[TB] FAIL basic_busy: %0d cycles of 1..8 wrong, expected busy=1 done=0 throughout", bad_busy);
    end
    tick();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_done_cycle9: done=%b busy=%b expected 1 0", done, busy);
    end
    checks++;
    if (quotient !== 8'd28 || remainder !== 8'd4 || div_by_zero !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_result: q=%0d r=%0d dz=%b expected 28 4 0", quotient, remainder, div_by_zero);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || quotient !== 8'd28 || remainder !== 8'd4) begin
      errors++;
      $display("[TB] FAIL basic_hold: done=%b busy=%b q=%0d r=%0d expected 0 0 28 4", done, busy, quotient, remainder);
    end
  endtask

  task automatic test_edges();
    int ta [7];
    int tb [7];
    int cyc;
    ta = '{255, 5, 0, 255, 1, 128, 254};
    tb = '{1, 9, 3, 255, 255, 2, 17};
    for (int i = 0; i < 7; i++) begin
      launch(ta[i], tb[i]);
      wait_done(1, cyc);
      checks++;
      if (cyc != 9) begin
        errors++;
        $display("[TB] FAIL edge_latency %0d/%0d: done at cycle %0d expected 9", ta[i], tb[i], cyc);
      end
      checks++;
      if (int'(quotient) != ref_q(ta[i], tb[i]) || int'(remainder) != ref_r(ta[i], tb[i]) || div_by_zero !== 1'b0) begin
        errors++;
        $display("[TB] FAIL edge_result %0d/%0d: q=%0d r=%0d dz=%b expected %0d %0d 0",
                 ta[i], tb[i], quotient, remainder, div_by_zero, ref_q(ta[i], tb[i]), ref_r(ta[i], tb[i]));
      end
      tick();
    end
  endtask

  task automatic test_div_zero();
    int cyc;
    launch(77, 0);
    wait_done(1, cyc);
    checks++;
    if (cyc != 9) begin
      errors++;
      $display("[TB] FAIL dz_latency: done at cycle %0d expected 9", cyc);
    end
    checks++;
    if (quotient !== 8'hFF || remainder !== 8'd77 || div_by_zero !== 1'b1) begin
      errors++;
      $display("[TB] FAIL dz_result: q=%0d r=%0d dz=%b expected 255 77 1", quotient, remainder, div_by_zero);
    end
    tick();
    checks++;
    if (div_by_zero !== 1'b1 || quotient !== 8'hFF) begin
      errors++;
      $display("[TB] FAIL dz_hold: q=%0d dz=%b expected 255 1", quotient, div_by_zero);
    end
    launch(10, 3);
    for (int c = 1; c < 9; c++) begin
      if (c == 4) begin
        checks++;
        if (div_by_zero !== 1'b1) begin
          errors++;
          $display("[TB] FAIL dz_hold_running: dz=%b expected 1 until done", div_by_zero);
        end
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || quotient !== 8'd3 || remainder !== 8'd1 || div_by_zero !== 1'b0) begin
      errors++;
      $display("[TB] FAIL dz_clear: done=%b q=%0d r=%0d dz=%b expected 1 3 1 0", done, quotient, remainder, div_by_zero);
    end
    tick();
  endtask

  task automatic test_start_while_busy();
    int cyc;
    int extra;
    launch(100, 10);
    tick();
    tick();
    tick();
    start    = 1'b1;
    dividend = 8'd9;
    divisor  = 8'd9;
    tick();
    start = 1'b0;
    wait_done(5, cyc);
    checks++;
    if (cyc != 9) begin
      errors++;
      $display("[TB] FAIL busy_start_latency: done at cycle %0d expected 9", cyc);
    end
    checks++;
    if (quotient !== 8'd10 || remainder !== 8'd0) begin
      errors++;
      $display("[TB] FAIL busy_start_result: q=%0d r=%0d expected 10 0", quotient, remainder);
    end
    extra = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("[TB] FAIL busy_start_second_op: %0d active cycles seen, expected 0", extra);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    launch(200, 7);
    tick();
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || quotient !== 8'd0 || remainder !== 8'd0 || div_by_zero !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_state: busy=%b done=%b q=%0d r=%0d dz=%b expected all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (done === 1'b1) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("[TB] FAIL reset_mid_no_done: %0d done pulses seen, expected 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    int qa[$];
    int qb[$];
    int a;
    int b;
    int cyc;
    a = $urandom_range(0, 255);
    b = $urandom_range(0, 255);
    qa.push_back(a);
    qb.push_back(b);
    start    = 1'b1;
    dividend = 8'(a);
    divisor  = 8'(b);
    tick();
    for (int n = 0; n < 2000; n++) begin
      cyc = 1;
      while (done !== 1'b1 && cyc < 30) begin
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
        tick();
        cyc++;
      end
      a = qa.pop_front();
      b = qb.pop_front();
      checks++;
      if (cyc != 9 || busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL b2b_latency op %0d: done at cycle %0d busy=%b expected 9 0", n, cyc, busy);
      end
      checks++;
      if (int'(quotient) != ref_q(a, b) || int'(remainder) != ref_r(a, b) || div_by_zero !== (b == 0)) begin
        errors++;
        $display("[TB] FAIL b2b_result %0d/%0d: q=%0d r=%0d dz=%b expected %0d %0d %0d",
                 a, b, quotient, remainder, div_by_zero, ref_q(a, b), ref_r(a, b), (b == 0));
      end
      if (cyc >= 30) break;
      a = (n % 16 == 5) ? 255 : $urandom_range(0, 255);
      b = (n % 32 == 7) ? 0 : $urandom_range(0, 255);
      qa.push_back(a);
      qb.push_back(b);
      dividend = 8'(a);
      divisor  = 8'(b);
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("[TB] FAIL b2b_restart op %0d: done=%b busy=%b expected 0 1", n, done, busy);
      end
    end
    start = 1'b0;
    for (int c = 0; c < 12; c++) tick();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_edges();
    test_div_zero();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
